bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the parallel word width in bits (2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 0, the number of forced idle cycles after each frame (0..15).
REQ-003 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load_valid, input, 1, upstream word offered.
REQ-006 SHALL have port load_data, input, DATA_W, word to serialize.
REQ-007 SHALL have port load_ready, output, 1, block can accept a word this cycle.
REQ-008 SHALL have port ser_out, output, 1, serial bit stream, MSB first; drives the downstream sequence detector's serial input.
REQ-009 SHALL have port ser_valid, output, 1, ser_out carries a frame bit this cycle.
REQ-010 SHALL have port busy, output, 1, state is not IDLE.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse after the last frame bit.

Function
REQ-012 SHALL implement states IDLE, SHIFT, PARITY, GAP; PARITY exists only when PARITY_EN is defined.
REQ-013 SHALL drive load_ready high only in IDLE and not in reset; a word is accepted on an edge where load_valid and load_ready are both high.
REQ-014 SHALL, on accept, load load_data into a shift register, set ser_out to load_data[DATA_W-1], set ser_valid to 1, clear the bit counter, and enter SHIFT; first bit appears the cycle after the accept edge.
REQ-015 SHALL in SHIFT present one bit per cycle, MSB to LSB, for exactly DATA_W consecutive cycles with ser_valid=1.
REQ-016 SHALL after the LSB cycle go to PARITY if compiled in, otherwise to GAP if GAP_CYCLES>0, otherwise to IDLE.
REQ-017 SHALL in GAP hold ser_valid=0 and ser_out=0 for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-018 SHALL drive ser_out=0 and ser_valid=0 whenever no frame bit is presented.
REQ-019 SHALL pulse frame_done high for exactly one cycle: the first cycle after the last frame bit (LSB or parity bit).
REQ-020 SHALL ignore load_valid and load_data while busy; a held load_valid is accepted on the first IDLE cycle; at least one IDLE cycle separates frames.
REQ-021 SHALL keep the bit counter width ceil(log2(DATA_W+1)) with no wrap inside a frame.

Reset
REQ-022 SHALL on reset enter IDLE and set ser_out=0, ser_valid=0, busy=0, frame_done=0, the counters to 0 and the shift register to 0.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame at the next edge, emit no frame_done, and not resume the aborted word.
REQ-024 SHALL hold load_ready=0 while reset is high; load_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-025 SHALL with macro SERIALIZER_PARITY_EN defined append one even-parity bit (XOR of all data bits) after the LSB, with ser_valid=1, giving frames of DATA_W+1 bits.
REQ-026 SHALL with SERIALIZER_PARITY_EN undefined omit the PARITY state and its logic; frames are DATA_W bits.

Verification
REQ-027 SHALL cover DATA_W=8, no macro: accept 0xD0 -> ser_out 1,1,0,1,0,0,0,0 over 8 cycles with ser_valid=1, then frame_done=1 for 1 cycle and load_ready=1.
REQ-028 SHALL cover SERIALIZER_PARITY_EN defined: accept 0xD0 -> 8 data bits then parity bit 1 (9 valid cycles); accept 0xD8 -> parity bit 0.
REQ-029 SHALL cover GAP_CYCLES=2 with load_valid held high and words 0xA5 then 0x3C -> second word's first bit starts exactly 8+2+2 cycles after the first word's first bit, with ser_valid=0 in between.
REQ-030 SHALL cover reset pulsed at bit 4 of 0xFF -> next cycle ser_valid=0 and busy=0, no frame_done, and a new word is accepted normally afterwards.
REQ-031 SHALL cover load_valid toggled while busy -> no extra word accepted, and the in-flight bit sequence is unchanged.
REQ-032 SHALL cover end-to-end connection to the downstream detector: stream 0xD0 -> detector z=1 on the fourth serial bit.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: accepts a parallel word and streams it MSB first, one bit
// per clock, with ser_valid marking frame bits. Feeds the downstream sequence
// detector's serial input.
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity bit
// after the LSB. Without it, frames are exactly DATA_W bits.
// After the last frame bit, one frame_done cycle follows. If GAP_CYCLES > 0,
// GAP_CYCLES more forced idle cycles follow before the block returns to IDLE.
module bit_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd3
  } state_e;
`endif

  // State entered once the last frame bit has been presented.
  localparam state_e POST_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              accept;

  // Ready only in IDLE and never while reset is asserted.
  assign load_ready = (state_q == ST_IDLE) && !reset;
  assign accept     = load_valid && load_ready;

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // The MSB goes straight to the output.
          // The shift register keeps only the bits still to be sent.
          state_d     = ST_SHIFT;
          shift_d     = {load_data[DATA_W-2:0], 1'b0};
          bit_cnt_d   = '0;
          ser_out_d   = load_data[DATA_W-1];
          ser_valid_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          parity_d    = ^load_data;
`endif
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
          state_d     = ST_PARITY;
          ser_out_d   = parity_q;
          ser_valid_d = 1'b1;
`else
          state_d      = POST_FRAME;
          gap_cnt_d    = '0;
          frame_done_d = 1'b1;
`endif
        end else begin
          shift_d     = {shift_q[DATA_W-2:0], 1'b0};
          ser_out_d   = shift_q[DATA_W-1];
          ser_valid_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end
      end

`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: begin
        state_d      = POST_FRAME;
        gap_cnt_d    = '0;
        frame_done_d = 1'b1;
      end
`endif

      ST_GAP: begin
        // The first GAP cycle carries frame_done.
        // GAP_CYCLES further idle cycles follow it.
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for bit_serializer.
// Instance dut runs with no gap. Instance dut_gap runs with GAP_CYCLES=2.
// Defining SERIALIZER_PARITY_EN adds the parity bit to the expected frames.
module tb_bit_serializer;

  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 2;
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned PB  = 1;
`else
  localparam int unsigned PB  = 0;
`endif
  localparam int unsigned FLEN   = DW + PB;
  localparam int unsigned PERIOD = FLEN + GAP + 2;
  localparam int unsigned WIN    = PERIOD + FLEN + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load_valid, load_ready, ser_out, ser_valid, busy, frame_done;
  logic [DW-1:0] load_data;
  logic          g_reset, g_valid, g_ready, g_out, g_sv, g_busy, g_done;
  logic [DW-1:0] g_data;

  bit_serializer #(.DATA_W(DW), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .frame_done(frame_done)
  );

  bit_serializer #(.DATA_W(DW), .GAP_CYCLES(GAP)) dut_gap (
    .clk(clk), .reset(g_reset), .load_valid(g_valid), .load_data(g_data),
    .load_ready(g_ready), .ser_out(g_out), .ser_valid(g_sv),
    .busy(g_busy), .frame_done(g_done)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t sb_q[$];
  int   checks      = 0;
  int   failures    = 0;
  logic exp_done    = 1'b0;
  int   bits_popped = 0;
  int   frame_idx   = 0;
  int   det_st      = 0;
  int   det_hit     = -1;
  logic mon_en      = 1'b0;

  // Count one comparison and report it if it mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the expected bits of one frame: MSB first, parity last if enabled.
  task automatic push_frame(input logic [DW-1:0] w);
    exp_bit_t e;
    for (int i = DW - 1; i >= 0; i--) begin
      e.b    = w[i];
      e.last = (i == 0) && (PB == 0);
      sb_q.push_back(e);
    end
`ifdef SERIALIZER_PARITY_EN
    e.b    = ^w;
    e.last = 1'b1;
    sb_q.push_back(e);
`endif
  endtask

  // Offer a word, wait for acceptance, then release load_valid.
  task automatic send(input logic [DW-1:0] w);
    int n;
    n = 0;
    @(negedge clk); #1;
    load_valid = 1'b1;
    load_data  = w;
    while (load_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(load_ready), 32'd1);
    push_frame(w);
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = DW'($urandom);
  endtask

  // Wait for the frame to drain and the block to return to IDLE.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(sb_q.size() == 0 && busy === 1'b0 && frame_done === 1'b0) && n < 100);
    if (n >= 100) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Wait until the scoreboard has consumed the given number of bits.
  task automatic wait_bits(input int target);
    int n;
    n = 0;
    while (bits_popped < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("bit_timeout", 32'(bits_popped), 32'(target));
  endtask

  // Monitor: check outputs against the scoreboard and run the detector model.
  always @(negedge clk) begin
    logic     got;
    logic     z;
    exp_bit_t e;
    if (mon_en) begin
      got = 1'b0;
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      exp_done = 1'b0;
      if (sb_q.size() == 0) begin
        chk("ser_valid_no_word", 32'(ser_valid), 32'd0);
      end else if (ser_valid === 1'b1) begin
        e   = sb_q.pop_front();
        got = 1'b1;
        chk("ser_out", 32'(ser_out), 32'(e.b));
        // Downstream detector model: overlapping "1101", Mealy output.
        if (frame_idx == 0) det_st = 0;
        z = 1'b0;
        case (det_st)
          0: det_st = ser_out ? 1 : 0;
          1: det_st = ser_out ? 2 : 0;
          2: det_st = ser_out ? 2 : 3;
          default: begin
            if (ser_out) begin
              z      = 1'b1;
              det_st = 1;
            end else begin
              det_st = 0;
            end
          end
        endcase
        if (z && det_hit < 0) det_hit = frame_idx;
        exp_done  = e.last;
        frame_idx = e.last ? 0 : frame_idx + 1;
        bits_popped++;
      end
      if (!got) chk("idle_ser_out", 32'(ser_out), 32'd0);
      chk("busy", 32'(busy), 32'(got));
      chk("load_ready", 32'(load_ready), 32'(!got && !reset));
      if (reset) begin
        sb_q.delete();
        exp_done  = 1'b0;
        frame_idx = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ga, gb;
    logic [4:0]    obs_s, exp_s;
    logic          sv_s [WIN];
    int            base, first2;

    reset = 1'b1; g_reset = 1'b1;
    load_valid = 1'b0; load_data = '0;
    g_valid = 1'b0; g_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_gap_ready", 32'(g_ready), 32'd0);
    #1;
    reset = 1'b0; g_reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(load_ready), 32'd1);

    // 0xD0: the detector must fire on the fourth serial bit.
    det_hit = -1;
    send(8'hD0);
    wait_idle();
    chk("detector_z_bit", 32'(det_hit), 32'd3);

    // Two words offered back to back, then random words.
    send(8'hD8);
    send(8'hA5);
    wait_idle();
    for (int i = 0; i < 4; i++) send(DW'($urandom));
    wait_idle();

    // load_valid toggles while busy: no extra word may be accepted.
    send(8'h96);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      load_valid = ~load_valid;
      load_data  = DW'($urandom);
    end
    load_valid = 1'b0;
    wait_idle();

    // Reset while bit 4 of 0xFF is on the line.
    base = bits_popped;
    send(8'hFF);
    wait_bits(base + 5);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ser_valid", 32'(ser_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    send(8'h5A);
    wait_idle();

    // GAP_CYCLES=2 instance, load_valid held high across two words.
    ga = 8'hA5; gb = 8'h3C;
    @(negedge clk); #1;
    g_valid = 1'b1; g_data = ga;
    for (int n = 0; n < 20 && g_ready !== 1'b1; n++) begin
      @(negedge clk); #1;
    end
    chk("gap_first_ready", 32'(g_ready), 32'd1);
    @(posedge clk); #1;
    g_data = gb;
    first2 = -1;
    for (int k = 0; k < int'(WIN); k++) begin
      @(negedge clk);
      sv_s[k] = g_sv;
      // Expected {busy, ready, frame_done, ser_valid, ser_out} for sample k.
      exp_s = '0;
      exp_s[4] = (k != int'(PERIOD) - 1);
      exp_s[3] = (k == int'(PERIOD) - 1);
      exp_s[2] = (k == int'(FLEN)) || (k == int'(PERIOD + FLEN));
      if (k < int'(DW)) begin
        exp_s[1] = 1'b1; exp_s[0] = ga[DW - 1 - k];
      end else if (k < int'(FLEN)) begin
        exp_s[1] = 1'b1; exp_s[0] = ^ga;
      end else if (k >= int'(PERIOD) && k < int'(PERIOD + DW)) begin
        exp_s[1] = 1'b1; exp_s[0] = gb[DW - 1 - (k - int'(PERIOD))];
      end else if (k >= int'(PERIOD + DW) && k < int'(PERIOD + FLEN)) begin
        exp_s[1] = 1'b1; exp_s[0] = ^gb;
      end
      obs_s = {g_busy, g_ready, g_done, g_sv, g_out};
      chk($sformatf("gap_sample_%0d", k), 32'(obs_s), 32'(exp_s));
      if (k == int'(PERIOD)) begin
        #1 g_valid = 1'b0;
      end
    end
    for (int k = int'(FLEN); k < int'(WIN); k++) begin
      if (first2 < 0 && sv_s[k] === 1'b1) first2 = k;
    end
    chk("gap_frame_period", 32'(first2), 32'(PERIOD));

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
